// File: rtl/hazard_sequencer.sv
// Hazard/stall controller for the 5-stage pipeline.
// It drives the PC, IF/ID and ID/EX controls for load-use stalls, taken-branch flushes
// and multi-cycle multiplies, and keeps a saturating stall-cycle counter.
// Latency: outputs are combinational from state and inputs and take effect at the next clk edge.
// Backpressure: pc_write/ifid_write low stalls the front end; ex_hold freezes EX during a multiply.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   id_rs, id_rt      source register fields of the instruction in ID
//   id_uses_rt        the ID instruction reads rt as a source
//   ex_mem_read       the instruction in EX is a load
//   ex_rt             destination register of the load in EX
//   ex_is_mul         the instruction in EX is a multiply
//   branch_taken      the branch in EX resolved taken this cycle
//   pc_write          PC update enable
//   ifid_write        IF/ID load enable
//   ifid_flush        clear IF/ID at the next edge
//   idex_bubble       zero the ID/EX control word at the next edge
//   ex_hold           ID/EX and EX state retain their contents
//   busy              a multiply sequence is in progress
//   stall_count       cycles with pc_write=0 since reset, saturating
module hazard_sequencer #(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        ex_is_mul,
    input  logic        branch_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        ex_hold,
    output logic        busy,
    output logic [15:0] stall_count
);

    typedef enum logic {
        RUN = 1'b0,
        MUL = 1'b1
    } state_t;

    // Cycles still to hold after the trigger cycle, not counting the release cycle.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_CYCLES - 2);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      stall_count_q, stall_count_d;
    logic             lu;

    // Register $0 is hard-wired to zero and can never be a real dependency.
    always_comb begin
        lu = ex_mem_read && (ex_rt != 5'd0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        ex_hold     = 1'b0;
        busy        = 1'b0;

        if (state_q == RUN) begin
            if (ex_is_mul) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                ex_hold    = 1'b1;
                busy       = 1'b1;
                state_d    = MUL;
                cnt_d      = CNT_INIT;
            end else if (branch_taken) begin
                // The ID instruction is squashed, so any load-use stall is moot.
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (lu) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end else begin
            busy = 1'b1;
            if (cnt_q != '0) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                ex_hold    = 1'b1;
                cnt_d      = cnt_q - 1'b1;
            end else begin
                // Release cycle: the multiply leaves EX now. ex_is_mul is still
                // high here and is deliberately ignored.
                state_d = RUN;
            end
        end

        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
            ex_hold     = 1'b0;
            busy        = 1'b0;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (!pc_write && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
module tb_hazard_sequencer;

    localparam int MUL_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_mem_read, ex_is_mul, branch_taken;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, busy;
    logic [15:0] stall_count;

    hazard_sequencer #(.MUL_CYCLES(MUL_CYCLES), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_is_mul(ex_is_mul),
        .branch_taken(branch_taken),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .ex_hold(ex_hold), .busy(busy),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: cycles the current multiply still spends in EX, and the stall total.
    int mul_left = 0;
    int m_count  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"},    32'(pc_write),    0);
        chk({tag, "_ifw"},   32'(ifid_write),  0);
        chk({tag, "_flush"}, 32'(ifid_flush),  0);
        chk({tag, "_bub"},   32'(idex_bubble), 0);
        chk({tag, "_hold"},  32'(ex_hold),     0);
        chk({tag, "_busy"},  32'(busy),        0);
        chk({tag, "_cnt"},   32'(stall_count), 0);
    endtask

    // Called just after a falling edge; applies one cycle of inputs, checks, advances to the next falling edge.
    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic mr, input logic [4:0] ert, input logic mul, input logic br);
        logic e_pc, e_ifw, e_fl, e_bub, e_hold, e_busy, ifw_care, hit;
        id_rs = rs; id_rt = rt; id_uses_rt = urt;
        ex_mem_read = mr; ex_rt = ert; ex_is_mul = mul; branch_taken = br;
        #1;
        hit = mr && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));
        e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_hold = 0; e_busy = 0; ifw_care = 1;
        if (mul_left > 1 || (mul_left == 0 && mul)) begin
            e_pc = 0; e_ifw = 0; e_hold = 1; e_busy = 1;
        end else if (mul_left == 1) begin
            e_busy = 1;
        end else if (br) begin
            e_fl = 1; e_bub = 1; ifw_care = 0;
        end else if (hit) begin
            e_pc = 0; e_ifw = 0; e_bub = 1;
        end
        chk("pc_write",    32'(pc_write),    32'(e_pc));
        if (ifw_care) chk("ifid_write", 32'(ifid_write), 32'(e_ifw));
        chk("ifid_flush",  32'(ifid_flush),  32'(e_fl));
        chk("idex_bubble", 32'(idex_bubble), 32'(e_bub));
        chk("ex_hold",     32'(ex_hold),     32'(e_hold));
        chk("busy",        32'(busy),        32'(e_busy));
        chk("stall_count", 32'(stall_count), 32'(m_count));
        @(posedge clk);
        if (!e_pc && m_count < 65535) m_count++;
        if (mul_left > 0)  mul_left--;
        else if (mul)      mul_left = MUL_CYCLES - 1;
        @(negedge clk);
    endtask

    task automatic idle();
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    int base;

    initial begin
        rst = 1'b1;
        id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_mem_read = 0; ex_rt = 0;
        ex_is_mul = 0; branch_taken = 0;
        #1;
        chk_reset("reset");
        // Drive a hazard during reset: outputs must still be forced low.
        ex_is_mul = 1'b1; #1;
        chk("reset_mul_pc", 32'(pc_write), 0);
        chk("reset_mul_busy", 32'(busy), 0);
        ex_is_mul = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Load-use on rs: one stall cycle, then clear.
        step(5'd5, 5'd9, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        idle();
        chk("lu_count_1", 32'(stall_count), 1);
        // rt path gated by id_uses_rt, and $0 never stalls.
        step(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
        step(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
        step(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        idle();
        chk("rt_count_2", 32'(stall_count), 2);
        // Branch beats load-use; no stall counted.
        step(5'd5, 5'd9, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1);
        idle();
        chk("br_count_2", 32'(stall_count), 2);

        // Single multiply: 3 holds, 1 release, then idle.
        base = stall_count;
        for (int i = 0; i < MUL_CYCLES; i++) step(5'd5, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
        idle();
        chk("mul_stalls", 32'(stall_count) - 32'(base), MUL_CYCLES - 1);
        // Back-to-back: ex_is_mul high across two full sequences.
        base = stall_count;
        for (int i = 0; i < 2 * MUL_CYCLES; i++) step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        idle();
        chk("mul2_stalls", 32'(stall_count) - 32'(base), 2 * (MUL_CYCLES - 1));

        // Reset during the 2nd hold cycle.
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        ex_is_mul = 1'b0; #1;
        chk("mid_mul_hold", 32'(ex_hold), 1);
        rst = 1'b1; #1;
        chk_reset("mid_mul_rst");
        mul_left = 0; m_count = 0;
        @(negedge clk);
        rst = 1'b0;
        idle();
        idle();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                 1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 5) == 0));
        end

        // Saturation: a persistent load-use stall for 70000 cycles.
        for (int i = 0; i < 70000; i++) step(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
        chk("sat", 32'(stall_count), 32'hFFFF);
        step(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
        chk("sat_hold", 32'(stall_count), 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
